fetch_unit: RTL

//   Instruction fetch stage directly upstream of the control decoder: owns the PC, requests
//   32-bit instructions from instruction memory over a req/ack handshake, and presents the

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// instruction until the datapath retires it, then steps to the sequential or branch PC.
module fetch_unit #(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter logic [63:0] PC_INC      = 64'd4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [63:0] startpc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [10:0] opcode,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        retire,
    input  logic        branch,
    input  logic        uncond_branch,
    input  logic        zero,
    input  logic [63:0] ext_imm,
    output logic        fault
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fault_q, fault_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        take;
    logic [63:0] next_pc;

    // An unknown branch control makes the if-condition false, so it falls through.
    always_comb begin
        take    = uncond_branch | (branch & zero);
        next_pc = pc_q + PC_INC;
        if (take) begin
            next_pc = pc_q + (ext_imm << 2);
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        cnt_d         = cnt_q;
        case (state_q)
            S_REQ: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    cnt_d         = 8'd0;
                    state_d       = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == CNT_LAST) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end
            end
            S_HOLD: begin
                if (retire) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            S_FAULT: begin
                instr_valid_d = 1'b0;
                fault_d       = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= startpc;
            instr_q       <= 32'd0;
            instr_pc_q    <= 64'd0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
            cnt_q         <= cnt_d;
        end
    end

    assign imem_req    = (state_q == S_REQ) && !reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:21];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fault       = fault_q;

endmodule
